// File: rtl/mem_boot_loader.sv
// Boot loader: streams an image into instruction and data SRAM, holds the core in
// reset for a few cycles, then hands both SRAM ports over to the core.
module mem_boot_loader #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int IMEM_LEN = 79,
    parameter int DMEM_LEN = 12,
    parameter int HOLD_CYC = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,

    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,

    input  logic              imem_csb_i,
    input  logic              imem_web_i,
    input  logic [ADDR_W-1:0] imem_addr_i,
    input  logic [DATA_W-1:0] imem_din_i,
    output logic              imem_csb_o,
    output logic              imem_web_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_din_o,

    input  logic              dmem_csb_i,
    input  logic              dmem_web_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_din_i,
    output logic              dmem_csb_o,
    output logic              dmem_web_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_din_o,

    output logic              core_rstn,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int HCW   = $clog2(HOLD_CYC + 1);

    localparam logic [CNT_W-1:0] I_LAST = CNT_W'(IMEM_LEN - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'((DMEM_LEN > 0) ? DMEM_LEN - 1 : 0);
    localparam logic [HCW-1:0]   H_LAST = HCW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        HOLD,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [HCW-1:0]   hold_cnt;
    logic             accept;

    assign accept = s_valid && s_ready;

    // s_ready, core_rstn and done are registered alongside the state so they are
    // glitch-free decodes of the current state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_cnt  <= '0;
            s_ready   <= 1'b0;
            core_rstn <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD_I;
                        cnt     <= '0;
                        s_ready <= 1'b1;
                    end
                end
                LOAD_I: begin
                    if (accept) begin
                        if (cnt == I_LAST) begin
                            cnt <= '0;
                            if (DMEM_LEN == 0) begin
                                state    <= HOLD;
                                s_ready  <= 1'b0;
                                hold_cnt <= '0;
                            end else begin
                                state <= LOAD_D;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                LOAD_D: begin
                    if (accept) begin
                        if (cnt == D_LAST) begin
                            cnt      <= '0;
                            state    <= HOLD;
                            s_ready  <= 1'b0;
                            hold_cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == H_LAST) begin
                        state     <= RUN;
                        core_rstn <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state     <= IDLE;
                    s_ready   <= 1'b0;
                    core_rstn <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // SRAM port steering: loader writes in LOAD_x, pass-through only in RUN.
    always_comb begin
        imem_csb_o  = 1'b1;
        imem_web_o  = 1'b1;
        imem_addr_o = '0;
        imem_din_o  = '0;
        dmem_csb_o  = 1'b1;
        dmem_web_o  = 1'b1;
        dmem_addr_o = '0;
        dmem_din_o  = '0;
        if (done) begin
            imem_csb_o  = imem_csb_i;
            imem_web_o  = imem_web_i;
            imem_addr_o = imem_addr_i;
            imem_din_o  = imem_din_i;
            dmem_csb_o  = dmem_csb_i;
            dmem_web_o  = dmem_web_i;
            dmem_addr_o = dmem_addr_i;
            dmem_din_o  = dmem_din_i;
        end else if (state == LOAD_I && accept) begin
            imem_csb_o  = 1'b0;
            imem_web_o  = 1'b0;
            imem_addr_o = cnt[ADDR_W-1:0];
            imem_din_o  = s_data;
        end else if (state == LOAD_D && accept) begin
            dmem_csb_o  = 1'b0;
            dmem_web_o  = 1'b0;
            dmem_addr_o = cnt[ADDR_W-1:0];
            dmem_din_o  = s_data;
        end
    end

endmodule

// File: doc/mem_boot_loader.md
MEM_BOOT_LOADER -- requirements
Module: mem_boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM word width.
REQ-003 SHALL have parameter IMEM_LEN, default 79, words loaded into instruction SRAM (1..2^ADDR_W).
REQ-004 SHALL have parameter DMEM_LEN, default 12, words loaded into data SRAM (0..2^ADDR_W).
REQ-005 SHALL have parameter HOLD_CYC, default 4, cycles core reset stays asserted after loading (>=1).
REQ-006 SHALL have port CLK  in  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port start  in  1  one-cycle load request.
REQ-009 SHALL have ports s_valid in 1, s_ready out 1, s_data in DATA_W: image word stream, beat accepted when s_valid&&s_ready.
REQ-010 SHALL have ports imem_csb_i in 1, imem_web_i in 1, imem_addr_i in ADDR_W, imem_din_i in DATA_W: core-side instruction SRAM request (from wrapper).
REQ-011 SHALL have ports imem_csb_o out 1, imem_web_o out 1, imem_addr_o out ADDR_W, imem_din_o out DATA_W: instruction SRAM port (csb/web active-low).
REQ-012 SHALL have ports dmem_csb_i/web_i/addr_i/din_i and dmem_csb_o/web_o/addr_o/din_o, same widths, data SRAM.
REQ-013 SHALL have port core_rstn  out  1  active-low core reset.
REQ-014 SHALL have port done  out  1  high while in RUN.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_I, LOAD_D, HOLD, RUN.
REQ-016 IDLE: s_ready=0, core_rstn=0, both SRAM ports deselected (csb_o=1, web_o=1, addr_o=0, din_o=0); start=1 -> LOAD_I, word counter cnt=0.
REQ-017 LOAD_I: s_ready=1; accepted beat drives imem_csb_o=0, imem_web_o=0, imem_addr_o=cnt, imem_din_o=s_data combinationally in the same cycle; cnt increments on each accepted beat.
REQ-018 LOAD_I: beat with cnt==IMEM_LEN-1 -> LOAD_D with cnt=0, or -> HOLD if DMEM_LEN==0.
REQ-019 LOAD_D: identical to LOAD_I on the dmem port; beat with cnt==DMEM_LEN-1 -> HOLD.
REQ-020 In LOAD_x, cycles with s_valid=0 SHALL leave memories deselected and cnt unchanged (stalls unbounded, no timeout).
REQ-021 The SRAM port not being loaded SHALL stay deselected; never both ports written in one cycle.
REQ-022 HOLD: s_ready=0, memories deselected, core_rstn=0; after exactly HOLD_CYC cycles -> RUN.
REQ-023 RUN: core_rstn=1, done=1, s_ready=0; *_o ports equal corresponding *_i ports combinationally (zero latency).
REQ-024 Outside RUN, *_i ports SHALL be ignored.
REQ-025 start outside IDLE SHALL be ignored; RUN exits only through RST.
REQ-026 cnt SHALL be ADDR_W+1 bits wide so IMEM_LEN=2^ADDR_W loads without wrap; addr_o = cnt[ADDR_W-1:0].
REQ-027 No s_data beat SHALL be accepted when s_ready=0; words accepted = IMEM_LEN+DMEM_LEN exactly per load.

Reset
REQ-028 RST=1 at a rising edge SHALL force IDLE, cnt=0, HOLD counter=0, from any state including mid-load.
REQ-029 Outputs after reset: s_ready=0, core_rstn=0, done=0, csb_o=1, web_o=1, addr_o=0, din_o=0 on both ports.
REQ-030 Memory contents written before a mid-load reset are not restored; a new start reloads from address 0.

Verification
REQ-031 Defaults, start, continuous s_valid with data=0x1000+i -> imem[0..78]=0x1000..0x104E, dmem[0..11]=0x104F..0x105A; core_rstn rises exactly 4 cycles after last beat.
REQ-032 s_valid toggled 1/0 each cycle -> identical memory contents; imem writes only on valid cycles, addresses consecutive.
REQ-033 DMEM_LEN=0, IMEM_LEN=4 -> 4 imem writes, zero dmem activity, HOLD entered after 4th beat.
REQ-034 RST asserted after 30 imem beats -> next cycle IDLE, s_ready=0, core_rstn=0; restart reloads addr 0..78.
REQ-035 In RUN drive imem_addr_i=0x155, dmem_web_i=0 -> same values on *_o in the same cycle; start pulse ignored, done stays 1.
